// File: rtl/seg7_if.sv
// Display-side bundle for the seven-segment scanner: data/controls in,
// segment/anode pins and frame marker out.
interface seg7_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    load;
    logic                    lz_en;
    logic [7:0]              seg_out;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    frame_start;

    modport master (
        output value, dp, load, lz_en,
        input  seg_out, anode, frame_start
    );

    modport slave (
        input  value, dp, load, lz_en,
        output seg_out, anode, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with per-slot
// blanking, frame-atomic updates and leading-zero suppression.
module seg7_scan_driver #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int BLANK_CYCLES     = 64,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    seg7_if.slave bus
);
    localparam int CNT_W     = $clog2(REFRESH_DIV);
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W     = 4 * NUM_DIGITS;
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
    localparam int BLANK_LIM = HAS_BLANK ? BLANK_CYCLES : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_LIM);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

    typedef enum logic {PH_BLANK = 1'b0, PH_ON = 1'b1} phase_t;

    function automatic logic [6:0] font(input logic [3:0] nib);
        logic [6:0] f;
        case (nib)
            4'h0:    f = 7'h40;
            4'h1:    f = 7'h79;
            4'h2:    f = 7'h24;
            4'h3:    f = 7'h30;
            4'h4:    f = 7'h19;
            4'h5:    f = 7'h12;
            4'h6:    f = 7'h02;
            4'h7:    f = 7'h78;
            4'h8:    f = 7'h00;
            4'h9:    f = 7'h10;
            4'hA:    f = 7'h08;
            4'hB:    f = 7'h03;
            4'hC:    f = 7'h46;
            4'hD:    f = 7'h21;
            4'hE:    f = 7'h06;
            4'hF:    f = 7'h0E;
            default: f = 7'h7F;
        endcase
        return f;
    endfunction

    logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0]      idx_r, idx_nxt_s;
    logic                  slot_end_s, boundary_s, boundary_d_r;
    phase_t                phase_r, phase_nxt_s;
    logic [VAL_W-1:0]      pend_val_r, disp_val_r;
    logic [NUM_DIGITS-1:0] pend_dp_r, disp_dp_r;
    logic                  pend_lz_r, disp_lz_r;
    logic [NUM_DIGITS-1:0] lz_blank_s, onehot_s, anode_nxt_s, anode_r;
    logic                  zero_run_s;
    logic [7:0]            seg_nxt_s, seg_r;
    logic                  frame_start_r;

    // Slot counter and digit index advance
    always_comb begin
        slot_end_s = (cnt_r == CNT_LAST);
        boundary_s = slot_end_s && (idx_r == IDX_LAST);
        if (slot_end_s) begin
            cnt_nxt_s = '0;
            idx_nxt_s = (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
            idx_nxt_s = idx_r;
        end
    end

    // Phase of the upcoming counter value; phase_r always tracks cnt_r
    always_comb begin
        if (HAS_BLANK && (cnt_nxt_s < CNT_BLANK)) begin
            phase_nxt_s = PH_BLANK;
        end else begin
            phase_nxt_s = PH_ON;
        end
    end

    // Scan state register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= '0;
            idx_r        <= '0;
            phase_r      <= HAS_BLANK ? PH_BLANK : PH_ON;
            boundary_d_r <= 1'b0;
        end else begin
            cnt_r        <= cnt_nxt_s;
            idx_r        <= idx_nxt_s;
            phase_r      <= phase_nxt_s;
            boundary_d_r <= boundary_s;
        end
    end

    // Pending capture; display only changes on the frame boundary, where a live load wins
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_val_r <= '0;
            pend_dp_r  <= '0;
            pend_lz_r  <= 1'b0;
            disp_val_r <= '0;
            disp_dp_r  <= '0;
            disp_lz_r  <= 1'b0;
        end else begin
            if (bus.load) begin
                pend_val_r <= bus.value;
                pend_dp_r  <= bus.dp;
                pend_lz_r  <= bus.lz_en;
            end else begin
                pend_val_r <= pend_val_r;
                pend_dp_r  <= pend_dp_r;
                pend_lz_r  <= pend_lz_r;
            end
            if (boundary_s && bus.load) begin
                disp_val_r <= bus.value;
                disp_dp_r  <= bus.dp;
                disp_lz_r  <= bus.lz_en;
            end else if (boundary_s) begin
                disp_val_r <= pend_val_r;
                disp_dp_r  <= pend_dp_r;
                disp_lz_r  <= pend_lz_r;
            end else begin
                disp_val_r <= disp_val_r;
                disp_dp_r  <= disp_dp_r;
                disp_lz_r  <= disp_lz_r;
            end
        end
    end

    // Leading-zero mask: digit k blanks while it and everything above it is zero
    always_comb begin
        lz_blank_s = '0;
        zero_run_s = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run_s    = zero_run_s && (disp_val_r[k*4 +: 4] == 4'h0);
            lz_blank_s[k] = disp_lz_r && zero_run_s;
        end
    end

    // Pin values for the current slot phase
    always_comb begin
        onehot_s    = NUM_DIGITS'(1'b1) << idx_r;
        seg_nxt_s   = 8'hFF;
        anode_nxt_s = ANODE_OFF;
        if (phase_r == PH_ON) begin
            anode_nxt_s    = onehot_s ^ ANODE_OFF;
            seg_nxt_s[6:0] = lz_blank_s[idx_r] ? 7'h7F : font(disp_val_r[{idx_r, 2'b00} +: 4]);
            seg_nxt_s[7]   = ~disp_dp_r[idx_r];
        end else begin
            anode_nxt_s = ANODE_OFF;
            seg_nxt_s   = 8'hFF;
        end
    end

    // Registered pins; frame_start lags the boundary so it lines up with digit 0's first output
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r         <= 8'hFF;
            anode_r       <= ANODE_OFF;
            frame_start_r <= 1'b0;
        end else begin
            seg_r         <= seg_nxt_s;
            anode_r       <= anode_nxt_s;
            frame_start_r <= boundary_d_r;
        end
    end

    assign bus.seg_out     = seg_r;
    assign bus.anode       = anode_r;
    assign bus.frame_start = frame_start_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a blanking/active-low build and a no-blank/active-high
// build scanned side by side against expected segment patterns.
module tb_seg7_scan_driver;
    logic clk;
    logic rst;

    seg7_if #(.NUM_DIGITS(4)) bus_a();
    seg7_if #(.NUM_DIGITS(4)) bus_b();

    assign bus_b.value = bus_a.value;
    assign bus_b.dp    = bus_a.dp;
    assign bus_b.load  = bus_a.load;
    assign bus_b.lz_en = bus_a.lz_en;

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic            lz;
        logic [3:0][7:0] seg;   // expected pattern, seg[d] = digit d
    } vec_t;

    typedef struct packed {
        logic       fs;
        logic [3:0] an_a;
        logic [7:0] seg_a;
        logic [3:0] an_b;
        logic [7:0] seg_b;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    vec_t vecs[7];
    vec_t v_zero, v_1111, v_9999, shown;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic ld);
        bus_a.value = v.value;
        bus_a.dp    = v.dp;
        bus_a.lz_en = v.lz;
        bus_a.load  = ld;
    endtask

    task automatic chk_reset_pins(input int c);
        chk("rst_anode_a", c, 32'(bus_a.anode), 32'h0000000F);
        chk("rst_seg_a",   c, 32'(bus_a.seg_out), 32'h000000FF);
        chk("rst_fs_a",    c, 32'(bus_a.frame_start), 32'h0);
        chk("rst_anode_b", c, 32'(bus_b.anode), 32'h0);
        chk("rst_seg_b",   c, 32'(bus_b.seg_out), 32'h000000FF);
    endtask

    task automatic wait_frame();
        int n = 0;
        while (bus_a.frame_start !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (bus_a.frame_start !== 1'b1) begin
            n_mis++;
            $display("FAIL frame_wait: frame_start not seen within %0d cycles", n);
        end
    endtask

    // Checks one 32-cycle frame starting at the current negedge; optional loads at cycle 5 and
    // cycle 30 (the latter lands on the frame-boundary edge).
    task automatic check_frame(input bit first, input vec_t sh,
                               input bit ld_a, input vec_t va, input bit ld_b, input vec_t vb);
        exp_t e;
        for (int c = 0; c < 32; c++) begin
            e.fs    = (c == 0) && !first;
            e.an_a  = ((c % 8) < 2) ? 4'hF : ~(4'b0001 << (c / 8));
            e.seg_a = ((c % 8) < 2) ? 8'hFF : sh.seg[c / 8];
            e.an_b  = 4'b0001 << (c / 8);
            e.seg_b = sh.seg[c / 8];
            sb.push_back(e);
        end
        for (int c = 0; c < 32; c++) begin
            e = sb.pop_front();
            chk("frame_start", c, 32'(bus_a.frame_start), 32'(e.fs));
            chk("anode_a",     c, 32'(bus_a.anode),       32'(e.an_a));
            chk("seg_a",       c, 32'(bus_a.seg_out),     32'(e.seg_a));
            chk("anode_b",     c, 32'(bus_b.anode),       32'(e.an_b));
            chk("seg_b",       c, 32'(bus_b.seg_out),     32'(e.seg_b));
            if (ld_a && c == 5) begin
                drive(va, 1'b1);
            end else if (ld_b && c == 30) begin
                drive(vb, 1'b1);
            end else begin
                bus_a.load = 1'b0;
            end
            @(negedge clk);
        end
        bus_a.load = 1'b0;
    endtask

    initial begin
        v_zero  = '{16'h0000, 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        v_1111  = '{16'h1111, 4'b0000, 1'b0, {8'hF9, 8'hF9, 8'hF9, 8'hF9}};
        v_9999  = '{16'h9999, 4'b0000, 1'b0, {8'h90, 8'h90, 8'h90, 8'h90}};
        vecs[0] = '{16'h12AF, 4'b0100, 1'b0, {8'hF9, 8'h24, 8'h88, 8'h8E}};
        vecs[1] = '{16'h0030, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hB0, 8'hC0}};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[3] = '{16'h0005, 4'b1000, 1'b1, {8'h7F, 8'hFF, 8'hFF, 8'h92}};
        vecs[4] = '{16'hC0D3, 4'b0001, 1'b1, {8'hC6, 8'hC0, 8'hA1, 8'h30}};
        vecs[5] = '{16'h4567, 4'b1111, 1'b0, {8'h19, 8'h12, 8'h02, 8'h78}};
        vecs[6] = '{16'hBE89, 4'b0000, 1'b0, {8'h83, 8'h86, 8'h80, 8'h90}};

        rst = 1'b1;
        drive(v_zero, 1'b0);
        repeat (3) @(negedge clk);
        chk_reset_pins(-1);
        rst = 1'b0;
        @(negedge clk);

        // First frame after reset: no pulse, display all zeros
        check_frame(1'b1, v_zero, 1'b0, v_zero, 1'b0, v_zero);
        shown = v_zero;

        for (int i = 0; i < 7; i++) begin
            wait_frame();
            check_frame(1'b0, shown, 1'b1, vecs[i], 1'b0, v_zero);
            shown = vecs[i];
        end

        // Two loads in one frame, the second on the boundary: only 9999 ever appears
        wait_frame();
        check_frame(1'b0, shown, 1'b1, v_1111, 1'b1, v_9999);
        check_frame(1'b0, v_9999, 1'b0, v_zero, 1'b0, v_zero);
        check_frame(1'b0, v_9999, 1'b0, v_zero, 1'b0, v_zero);

        // Reset during digit 2's ON phase
        wait_frame();
        repeat (19) @(negedge clk);
        chk("pre_rst_anode_a", 19, 32'(bus_a.anode), 32'h0000000B);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_pins(20);
        rst = 1'b0;
        @(negedge clk);
        check_frame(1'b1, v_zero, 1'b0, v_zero, 1'b0, v_zero);
        check_frame(1'b0, v_zero, 1'b0, v_zero, 1'b0, v_zero);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
